// File: rtl/fb_arb_pkg.sv
// ---------------------------------------------------------------------------
// fb_arb_pkg
// Shared types and helpers for the framebuffer write arbiter.
//   arb_state_e : arbiter FSM states (ARB = choosing a requester,
//                 SERVE = forwarding the granted stream)
//   rr_next()   : wrapping increment of a round-robin index; the wrap is a
//                 compare against n-1, so n need not be a power of two
// ---------------------------------------------------------------------------
package fb_arb_pkg;

   typedef enum logic {
      ARB   = 1'b0,
      SERVE = 1'b1
   } arb_state_e;

   function automatic int unsigned rr_next(input int unsigned idx,
                                           input int unsigned n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/fb_write_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority search. Scans i_req starting at index
// i_base and moving upward with wrap N-1 -> 0; reports the first set index.
//   i_req  [N-1:0]     request vector
//   i_base [IDX_W-1:0] index searched first (must be < N)
//   o_idx  [IDX_W-1:0] first asserted index at or after i_base (0 if none)
//   o_any              at least one request is asserted
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int unsigned N     = 2,
   parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_base,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   int unsigned w_cand;
   logic        w_hit;

   always_comb begin
      o_idx  = '0;
      o_any  = 1'b0;
      w_cand = 0;
      w_hit  = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         // candidate = (base + k) mod N, reduced with a single subtract
         w_cand = 32'(i_base) + k;
         if (w_cand >= N) begin
            w_cand = w_cand - N;
         end
         // constant-index lookup keeps the select free of width games
         w_hit = 1'b0;
         for (int unsigned j = 0; j < N; j++) begin
            if (w_cand == j) begin
               w_hit = i_req[j];
            end
         end
         if (w_hit && !o_any) begin
            o_any = 1'b1;
            o_idx = IDX_W'(w_cand);
         end
      end
   end

endmodule

// File: rtl/fb_write_arbiter.sv
// ---------------------------------------------------------------------------
// fb_write_arbiter
// Round-robin arbiter sharing one framebuffer write stream between NUM_REQ
// pixel producers. A grant lasts up to MAX_BURST handshakes, or until the
// granted producer drops valid; each grant change costs one ARB cycle.
// Data path in SERVE is pure combinational forwarding.
//   clk, reset             clock, asynchronous active-high reset
//   req_valid/req_ready    per-requester handshake
//   req_addr/req_color     flattened per-requester payload, slice i = req i
//   out_valid/out_ready    stream towards fb_writer
//   out_addr/out_color     granted requester's payload
//   grant_id               current / last granted requester
//   busy                   high while serving a grant
// ---------------------------------------------------------------------------
module fb_write_arbiter
   import fb_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 2,
   parameter int unsigned PIXEL_BITS     = 12,
   parameter int unsigned AXI_ADDR_WIDTH = 20,
   parameter int unsigned MAX_BURST      = 8,
   localparam int unsigned ID_BITS       = $clog2(NUM_REQ)
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*PIXEL_BITS-1:0]     req_color,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [AXI_ADDR_WIDTH-1:0]         out_addr,
   output logic [PIXEL_BITS-1:0]             out_color,
   output logic [ID_BITS-1:0]                grant_id,
   output logic                              busy
);

   localparam int unsigned BC_W = $clog2(MAX_BURST + 1);

   arb_state_e          r_state;
   logic [ID_BITS-1:0]  r_grant;
   logic [ID_BITS-1:0]  r_rr;
   logic [BC_W-1:0]     r_cnt;

   logic [ID_BITS-1:0]  w_pick;
   logic                w_any;
   logic                w_sel_valid;
   logic [ID_BITS-1:0]  w_next_rr;

   logic [AXI_ADDR_WIDTH-1:0] w_addr_arr  [NUM_REQ];
   logic [PIXEL_BITS-1:0]     w_color_arr [NUM_REQ];

   // Unflatten the payload buses so the grant can index them directly.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_addr_arr[gi]  = req_addr[gi*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
      assign w_color_arr[gi] = req_color[gi*PIXEL_BITS +: PIXEL_BITS];
   end

   rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (ID_BITS)
   ) u_pick (
      .i_req  (req_valid),
      .i_base (r_rr),
      .o_idx  (w_pick),
      .o_any  (w_any)
   );

   assign w_sel_valid = req_valid[r_grant];
   assign w_next_rr   = ID_BITS'(rr_next(32'(r_grant), NUM_REQ));

   // Forwarding from the granted slice; addr/color are don't-care outside
   // SERVE but still follow the (reset-zero) grant.
   assign out_addr  = w_addr_arr[r_grant];
   assign out_color = w_color_arr[r_grant];
   assign out_valid = (r_state == SERVE) && w_sel_valid;
   assign busy      = (r_state == SERVE);
   assign grant_id  = r_grant;

   always_comb begin
      req_ready = '0;
      if (r_state == SERVE) begin
         req_ready[r_grant] = out_ready;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ARB;
         r_grant <= '0;
         r_rr    <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ARB: begin
               if (w_any) begin
                  r_grant <= w_pick;
                  r_cnt   <= '0;
                  r_state <= SERVE;
               end
            end
            SERVE: begin
               if (!w_sel_valid) begin
                  // idle release: producer went quiet, hand over fairly
                  r_rr    <= w_next_rr;
                  r_state <= ARB;
               end else if (out_ready) begin
                  if (r_cnt == BC_W'(MAX_BURST - 1)) begin
                     r_rr    <= w_next_rr;
                     r_state <= ARB;
                  end else begin
                     r_cnt <= r_cnt + BC_W'(1);
                  end
               end
            end
            default: r_state <= ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_write_arbiter.sv
module tb_fb_write_arbiter;

   localparam int N  = 3;
   localparam int MB = 2;
   localparam int AW = 20;
   localparam int CW = 12;
   localparam int IW = $clog2(N);

   typedef struct packed {
      logic [AW-1:0] a;
      logic [CW-1:0] c;
   } pix_t;

   typedef struct {
      int   src;
      pix_t p;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*AW-1:0]   req_addr;
   logic [N*CW-1:0]   req_color;
   logic              out_valid;
   logic              out_ready;
   logic [AW-1:0]     out_addr;
   logic [CW-1:0]     out_color;
   logic [IW-1:0]     grant_id;
   logic              busy;

   fb_write_arbiter #(
      .NUM_REQ        (N),
      .PIXEL_BITS     (CW),
      .AXI_ADDR_WIDTH (AW),
      .MAX_BURST      (MB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_color (req_color),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_color (out_color),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // producers
   pix_t pq [N][$];
   bit   cur_v [N];
   pix_t cur_p [N];
   bit   rdy;
   int   pct_present;
   int   pct_ready;

   // reference model: who owns the stream, where the next search starts,
   // pixels moved in the current grant, last grant shown on grant_id
   int owner;
   int next_start;
   int taken;
   int last_grant;
   int hs_src;

   // per-cycle expectations and the handshake scoreboard
   bit           chk_en = 1'b0;
   bit           e_valid;
   bit           e_busy;
   logic [N-1:0] e_ready;
   int           e_grant;
   exp_t         sb [$];
   bit           log_en = 1'b0;
   int           src_log [$];

   int seq_cont [12] = '{0, 0, 1, 1, 2, 2, 0, 0, 1, 1, 2, 2};
   int seq_early [4] = '{0, 1, 1, 1};
   int seq_wrap  [6] = '{0, 0, 2, 2, 0, 2};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      owner      = -1;
      next_start = 0;
      taken      = 0;
      last_grant = 0;
      hs_src     = -1;
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i]           = cur_v[i];
         req_addr[i*AW +: AW]   = cur_p[i].a;
         req_color[i*CW +: CW]  = cur_p[i].c;
      end
      out_ready = rdy;
   endtask

   // What the arbiter must show this cycle given the model and current inputs.
   task automatic compute_exp();
      hs_src  = -1;
      e_busy  = (owner >= 0);
      e_valid = (owner >= 0) && cur_v[owner];
      e_ready = '0;
      if (owner >= 0) e_ready[owner] = rdy;
      e_grant = last_grant;
      if (e_valid && rdy) begin
         hs_src = owner;
         sb.push_back('{owner, cur_p[owner]});
      end
   endtask

   // Advance the model across a clock edge using the inputs held last cycle.
   task automatic model_edge();
      if (owner < 0) begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (next_start + k) % N;
            if (owner < 0 && cur_v[c]) begin
               owner      = c;
               taken      = 0;
               last_grant = c;
            end
         end
      end else if (!cur_v[owner]) begin
         next_start = (owner + 1) % N;
         owner      = -1;
      end else if (rdy) begin
         taken++;
         if (taken == MB) begin
            next_start = (owner + 1) % N;
            owner      = -1;
         end
      end
      if (hs_src >= 0) cur_v[hs_src] = 1'b0;
   endtask

   task automatic step(input bit rst_now);
      @(posedge clk);
      #1;
      if (reset) reset = 1'b0;
      else       model_edge();
      for (int i = 0; i < N; i++) begin
         if (!cur_v[i] && pq[i].size() > 0 && $urandom_range(99) < pct_present) begin
            cur_v[i] = 1'b1;
            cur_p[i] = pq[i].pop_front();
         end
      end
      rdy = ($urandom_range(99) < pct_ready);
      drive();
      if (rst_now) begin
         reset = 1'b1;
         model_reset();
      end
      compute_exp();
      chk_en = 1'b1;
      if (rst_now) begin
         #1;
         check("rst_out_valid", out_valid, 0);
         check("rst_busy", busy, 0);
         check("rst_req_ready", req_ready, 0);
      end
   endtask

   function automatic bit pending();
      bit p;
      p = 1'b0;
      for (int i = 0; i < N; i++) if (cur_v[i] || pq[i].size() > 0) p = 1'b1;
      return p;
   endfunction

   task automatic drain(input int max_cycles);
      int cnt;
      cnt = 0;
      while (pending() && cnt < max_cycles) begin
         step(1'b0);
         cnt++;
      end
      n_chk++;
      if (pending()) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d cycles required < %0d", cnt, max_cycles);
      end
      step(1'b0);
   endtask

   task automatic check_log(input string name, input int len, input int seq [12]);
      check({name, "_len"}, src_log.size(), len);
      for (int i = 0; i < len && i < src_log.size(); i++) begin
         check($sformatf("%s_%0d", name, i), src_log[i], seq[i]);
      end
      src_log.delete();
   endtask

   // monitor
   always @(negedge clk) begin
      if (chk_en) begin
         check("out_valid", out_valid, e_valid);
         check("busy", busy, e_busy);
         check("req_ready", req_ready, e_ready);
         check("grant_id", grant_id, e_grant);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("hs_unexpected", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("hs_src", grant_id, e.src);
               check("hs_addr", out_addr, e.p.a);
               check("hs_color", out_color, e.p.c);
               if (log_en) src_log.push_back(int'(grant_id));
            end
         end
      end
   end

   initial begin
      int tmp [12];
      bit did_mid_rst;

      reset       = 1'b1;
      rdy         = 1'b0;
      pct_present = 100;
      pct_ready   = 50;
      for (int i = 0; i < N; i++) begin
         cur_v[i] = 1'b0;
         cur_p[i] = '0;
      end
      model_reset();
      drive();
      repeat (3) @(posedge clk);

      // idle: nothing requested for 20 cycles
      repeat (20) step(1'b0);

      // single requester, 10 pixels in order
      for (int k = 0; k < 10; k++) pq[1].push_back('{AW'(32'h100 + k), CW'($urandom)});
      pct_ready = 100;
      drain(200);

      // contention: all three continuously valid
      step(1'b1);
      step(1'b0);
      for (int i = 0; i < N; i++)
         for (int k = 0; k < 4; k++) pq[i].push_back('{AW'(i * 32'h1000 + k), CW'($urandom)});
      log_en = 1'b1;
      drain(200);
      log_en = 1'b0;
      check_log("cont_seq", 12, seq_cont);

      // backpressure: out_ready low for 5 SERVE cycles
      step(1'b1);
      step(1'b0);
      pq[0].push_back('{AW'(32'h2A), CW'(32'hF00)});
      pct_ready = 0;
      step(1'b0);
      for (int c = 0; c < 5; c++) begin
         step(1'b0);
         #1;
         check("bp_valid", out_valid, 1);
         check("bp_addr", out_addr, 32'h2A);
         check("bp_color", out_color, 32'hF00);
      end
      pct_ready = 100;
      drain(50);

      // early release: req0 one pixel, req1 three
      step(1'b1);
      step(1'b0);
      pq[0].push_back('{AW'(32'h500), CW'(32'h111)});
      for (int k = 0; k < 3; k++) pq[1].push_back('{AW'(32'h600 + k), CW'(32'h222)});
      log_en = 1'b1;
      drain(100);
      log_en = 1'b0;
      tmp = '{default: 0};
      for (int i = 0; i < 4; i++) tmp[i] = seq_early[i];
      check_log("early_seq", 4, tmp);

      // non-power-of-two wrap: only req0 and req2
      step(1'b1);
      step(1'b0);
      for (int k = 0; k < 3; k++) begin
         pq[0].push_back('{AW'(32'h700 + k), CW'($urandom)});
         pq[2].push_back('{AW'(32'h900 + k), CW'($urandom)});
      end
      log_en = 1'b1;
      drain(100);
      log_en = 1'b0;
      tmp = '{default: 0};
      for (int i = 0; i < 6; i++) tmp[i] = seq_wrap[i];
      check_log("wrap_seq", 6, tmp);

      // randomized traffic with one reset in the middle of a grant
      pct_present = 70;
      pct_ready   = 70;
      did_mid_rst = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < N; i++)
            if (pq[i].size() < 3 && $urandom_range(99) < 20)
               pq[i].push_back('{AW'($urandom), CW'($urandom)});
         if (!did_mid_rst && cyc >= 1500 && owner >= 0) begin
            did_mid_rst = 1'b1;
            step(1'b1);
         end else begin
            step(1'b0);
         end
      end
      pct_present = 100;
      pct_ready   = 100;
      drain(500);
      check("mid_reset_done", did_mid_rst, 1);
      check("sb_empty", sb.size(), 0);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
